// File: rtl/frontend_pkg.sv
// Shared front-end types and default parameters for the PC generator and its
// branch-resolve queue.
package frontend_pkg;

  localparam int unsigned          XLEN_DEFAULT        = 64;
  localparam int unsigned          BRQ_DEPTH_DEFAULT   = 4;
  localparam int unsigned          FETCH_BYTES_DEFAULT = 4;
  localparam logic [XLEN_DEFAULT-1:0] RESET_PC_DEFAULT = 64'h8000_0000;

  // One unresolved branch: predicted direction and the PC of the other path.
  typedef struct packed {
    logic                    pred;
    logic [XLEN_DEFAULT-1:0] alt;
  } brq_entry_t;

endpackage

// File: rtl/brq_fifo.sv
// Show-ahead FIFO that holds unresolved branches. It has a synchronous flush,
// and push and pop may occur together even when the FIFO is full.
module brq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  // A pop frees the head slot in the same cycle, so a full FIFO can still accept a push.
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage has no reset; the count and pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/pc_redirect_unit.sv
// Front-end PC generator. Predicted branches queue their alternate path. A
// mispredict or an exception redirects fetch and flushes the queue.
module pc_redirect_unit
  import frontend_pkg::*;
#(
  parameter int unsigned     XLEN        = XLEN_DEFAULT,
  parameter int unsigned     BRQ_DEPTH   = BRQ_DEPTH_DEFAULT,
  parameter int unsigned     FETCH_BYTES = FETCH_BYTES_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC    = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            RST,
  input  logic            bp_isBranch,
  input  logic            bp_takenPredict,
  input  logic [XLEN-1:0] bp_target,
  input  logic            bru_res_valid,
  input  logic            bru_takenBranch,
  input  logic            excp_valid,
  input  logic [XLEN-1:0] excp_pc,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] fetch_pc,
  output logic            fetch_valid,
  output logic            flush,
  output logic            brq_full,
  output logic            brq_empty,
  output logic [31:0]     mispredict_cnt
);

  typedef struct packed {
    logic            pred;
    logic [XLEN-1:0] alt;
  } entry_t;

  logic [XLEN-1:0] pc_q, pc_d, pc_seq;
  logic [31:0]     mis_cnt_q, mis_cnt_d;
  entry_t          head, push_entry;
  logic            mispredict, pop_ok, fire, push;

  assign pc_seq     = pc_q + XLEN'(FETCH_BYTES);
  assign mispredict = bru_res_valid & ~brq_empty & (bru_takenBranch ^ head.pred);
  assign pop_ok     = bru_res_valid & ~brq_empty & ~mispredict & ~excp_valid;
  assign flush      = mispredict | excp_valid;

  // A branch stalls only if the queue is full and no correct resolve frees a slot.
  assign fetch_valid = ~RST & ~(bp_isBranch & brq_full & ~pop_ok);
  assign fire        = fetch_valid & fetch_ready;
  assign push        = fire & bp_isBranch & ~flush;

  assign push_entry.pred = bp_takenPredict;
  assign push_entry.alt  = bp_takenPredict ? pc_seq : bp_target;

  brq_fifo #(
    .DEPTH (BRQ_DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_brq (
    .clk     (clk),
    .rst_i   (RST),
    .flush_i (flush),
    .push_i  (push),
    .pop_i   (pop_ok),
    .wdata_i (push_entry),
    .rdata_o (head),
    .full_o  (brq_full),
    .empty_o (brq_empty)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    pc_d      = pc_q;
    mis_cnt_d = mis_cnt_q;
    if (excp_valid) begin
      pc_d = excp_pc;
    end else if (mispredict) begin
      pc_d = head.alt;
      if (mis_cnt_q != '1) mis_cnt_d = mis_cnt_q + 32'd1;
    end else if (fire) begin
      pc_d = (bp_isBranch && bp_takenPredict) ? bp_target : pc_seq;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (RST) begin
      pc_q      <= RESET_PC;
      mis_cnt_q <= '0;
    end else begin
      pc_q      <= pc_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign fetch_pc       = pc_q;
  assign mispredict_cnt = mis_cnt_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed, table-driven bench for pc_redirect_unit. Hand-written sequences
// cover the stall case and a reset in the middle of operation.
module tb_pc_redirect_unit;

  localparam logic [63:0] B = 64'h8000_0000;

  logic        clk;
  logic        RST;
  logic        bp_isBranch, bp_takenPredict;
  logic [63:0] bp_target;
  logic        bru_res_valid, bru_takenBranch;
  logic        excp_valid;
  logic [63:0] excp_pc;
  logic        fetch_ready;
  logic [63:0] fetch_pc;
  logic        fetch_valid, flush, brq_full, brq_empty;
  logic [31:0] mispredict_cnt;

  int n_checks = 0;
  int n_fails  = 0;

  pc_redirect_unit dut (
    .clk             (clk),
    .RST             (RST),
    .bp_isBranch     (bp_isBranch),
    .bp_takenPredict (bp_takenPredict),
    .bp_target       (bp_target),
    .bru_res_valid   (bru_res_valid),
    .bru_takenBranch (bru_takenBranch),
    .excp_valid      (excp_valid),
    .excp_pc         (excp_pc),
    .fetch_ready     (fetch_ready),
    .fetch_pc        (fetch_pc),
    .fetch_valid     (fetch_valid),
    .flush           (flush),
    .brq_full        (brq_full),
    .brq_empty       (brq_empty),
    .mispredict_cnt  (mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, isb, tk;
    logic [63:0] tgt;
    logic        bv, bt, ev;
    logic [63:0] epc;
    logic        rdy;
    logic [63:0] e_pc;
    logic        e_fv, e_fl, e_full, e_empty;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic isb, logic tk, logic [63:0] tgt,
                              logic bv, logic bt, logic ev, logic [63:0] epc, logic rdy,
                              logic [63:0] e_pc, logic e_fv, logic e_fl, logic e_full,
                              logic e_empty, logic [31:0] e_cnt);
    vec_t v;
    v.rst = rst; v.isb = isb; v.tk = tk; v.tgt = tgt;
    v.bv = bv; v.bt = bt; v.ev = ev; v.epc = epc; v.rdy = rdy;
    v.e_pc = e_pc; v.e_fv = e_fv; v.e_fl = e_fl; v.e_full = e_full;
    v.e_empty = e_empty; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    RST = v.rst; bp_isBranch = v.isb; bp_takenPredict = v.tk; bp_target = v.tgt;
    bru_res_valid = v.bv; bru_takenBranch = v.bt; excp_valid = v.ev; excp_pc = v.epc;
    fetch_ready = v.rdy;
  endtask

  // A resolve with an empty queue is a stimulus error, not a DUT failure mode.
  always @(negedge clk) begin
    if (!RST && bru_res_valid && brq_empty) begin
      n_fails++;
      $display("FAIL protocol: bru_res_valid with empty BRQ at %0t", $time);
    end
  end

  initial begin
    vec_t idle;
    //          rst isb tk tgt        bv bt ev epc       rdy  pc         fv fl fu em cnt
    vecs.push_back(mk(1, 0, 0, 64'h0,      0, 0, 0, 64'h0,   1,   B,         0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 64'h0,      0, 0, 0, 64'h0,   1,   B,         1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 64'h0,      0, 0, 0, 64'h0,   1,   B+'h4,     1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, B+'h100,    0, 0, 0, 64'h0,   1,   B+'h8,     1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 64'h0,      1, 1, 0, 64'h0,   1,   B+'h100,   1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, B+'h8,      0, 0, 0, 64'h0,   1,   B+'h104,   1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, B+'h100,    1, 0, 0, 64'h0,   1,   B+'h8,     1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, B+'h300,    0, 0, 0, 64'h0,   1,   B+'h108,   1, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 0, B+'h310,    0, 0, 0, 64'h0,   1,   B+'h10C,   1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, B+'h320,    0, 0, 0, 64'h0,   1,   B+'h110,   1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, B+'h330,    0, 0, 0, 64'h0,   1,   B+'h114,   1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, B+'h340,    0, 0, 0, 64'h0,   1,   B+'h118,   0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 1, 0, B+'h340,    1, 0, 0, 64'h0,   1,   B+'h118,   1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 64'h0,      1, 1, 1, B+'h200, 1,   B+'h11C,   1, 1, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 64'h0,      0, 0, 0, 64'h0,   1,   B+'h200,   1, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 64'h0,      0, 0, 0, 64'h0,   1,   B+'h204,   1, 0, 0, 1, 1));

    idle = mk(0, 0, 0, 64'h0, 0, 0, 0, 64'h0, 1, 64'h0, 0, 0, 0, 0, 0);

    drive(vecs[0]);
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(negedge clk);
      check($sformatf("v%0d fetch_pc", i),      fetch_pc,       vecs[i].e_pc);
      check($sformatf("v%0d fetch_valid", i),   64'(fetch_valid), 64'(vecs[i].e_fv));
      check($sformatf("v%0d flush", i),         64'(flush),       64'(vecs[i].e_fl));
      check($sformatf("v%0d brq_full", i),      64'(brq_full),    64'(vecs[i].e_full));
      check($sformatf("v%0d brq_empty", i),     64'(brq_empty),   64'(vecs[i].e_empty));
      check($sformatf("v%0d mispredict_cnt", i), 64'(mispredict_cnt), 64'(vecs[i].e_cnt));
      @(posedge clk); #1;
    end

    // fetch_ready low for three cycles: the PC must hold.
    drive(idle);
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d fetch_pc", i), fetch_pc, B+'h208);
      check($sformatf("stall%0d fetch_valid", i), 64'(fetch_valid), 64'd1);
      @(posedge clk); #1;
    end

    // Push a taken branch, then reset with a pending exception redirect.
    drive(idle);
    bp_isBranch = 1'b1; bp_takenPredict = 1'b1; bp_target = B+'h400;
    @(posedge clk); #1;
    drive(idle);
    @(negedge clk);
    check("pre_rst fetch_pc", fetch_pc, B+'h400);
    check("pre_rst brq_empty", 64'(brq_empty), 64'd0);
    @(posedge clk); #1;
    drive(idle);
    RST = 1'b1; excp_valid = 1'b1; excp_pc = B+'h500;
    @(negedge clk);
    check("rst fetch_valid", 64'(fetch_valid), 64'd0);
    @(posedge clk); #1;
    drive(idle);
    @(negedge clk);
    check("post_rst fetch_pc", fetch_pc, B);
    check("post_rst brq_empty", 64'(brq_empty), 64'd1);
    check("post_rst mispredict_cnt", 64'(mispredict_cnt), 64'd0);
    check("post_rst fetch_valid", 64'(fetch_valid), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst2 fetch_pc", fetch_pc, B+'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
